fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of decode / immediate generation in the RV32I core.
//  - Holds the PC, issues one word request at a time to instruction memory over a valid/ready handshake.
//  - Registers the returned instruction and its PC, and pre-extracts the 12-bit immediate field for the immediate generator.
//  - Presents {inst, inst_pc, inst_imm} to decode with a valid/ready handshake and accepts PC redirects from execute.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : RV32I fetch stage. Single-outstanding imem requests, registered
//            instruction/PC/immediate presented to decode, PC redirects.
//            Optional macro FETCH_MISALIGN_CHK_EN adds a sticky misalign_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [11:0] inst_imm,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic        misalign_err,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [6:0]  c_OP_STORE = 7'b0100011;
    localparam logic [31:0] c_PC_MASK  = 32'hFFFF_FFFC;

    function automatic logic [11:0] f_imm(input logic [31:0] i_word);
        if (i_word[6:0] == c_OP_STORE)
            f_imm = {i_word[31:25], i_word[11:7]};
        else
            f_imm = i_word[31:20];
    endfunction

    state_t      r_state,   w_state_nxt;
    logic [31:0] r_pc,      w_pc_nxt;
    logic [31:0] r_inst,    w_inst_nxt;
    logic [31:0] r_inst_pc, w_inst_pc_nxt;
    logic [11:0] r_imm,     w_imm_nxt;
    logic        r_valid,   w_valid_nxt;
    logic        w_redir;
    logic [31:0] w_target;

    assign w_target = redirect_pc & c_PC_MASK;

`ifdef FETCH_MISALIGN_CHK_EN
    logic r_misalign_err;
    // A misaligned redirect is dropped entirely; normal flow continues.
    assign w_redir = redirect_valid && (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst)
            r_misalign_err <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            r_misalign_err <= 1'b1;
    end

    assign misalign_err = r_misalign_err;
`else
    assign w_redir = redirect_valid;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        w_imm_nxt     = r_imm;
        w_valid_nxt   = r_valid;
        case (r_state)
            S_REQ: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = imem_req_ready ? S_DROP : S_REQ;
                end else if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_redir) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
                end else if (imem_rsp_valid) begin
                    w_inst_nxt    = imem_rsp_data;
                    w_inst_pc_nxt = r_pc;
                    w_imm_nxt     = f_imm(imem_rsp_data);
                    w_pc_nxt      = r_pc + 32'd4;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redir || inst_ready) begin
                    w_valid_nxt = 1'b0;
                    w_inst_nxt  = NOP_INST;
                    w_imm_nxt   = f_imm(NOP_INST);
                    w_state_nxt = S_REQ;
                    if (w_redir)
                        w_pc_nxt = w_target;
                end
            end
            S_DROP: begin
                if (w_redir)
                    w_pc_nxt = w_target;
                if (imem_rsp_valid)
                    w_state_nxt = S_REQ;
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_REQ;
            r_pc      <= RESET_PC & c_PC_MASK;
            r_inst    <= NOP_INST;
            r_inst_pc <= RESET_PC;
            r_imm     <= 12'h000;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_imm     <= w_imm_nxt;
            r_valid   <= w_valid_nxt;
        end
    end

    assign imem_req_valid = (r_state == S_REQ) && !rst;
    assign imem_addr      = r_pc;
    assign inst_valid     = r_valid;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign inst_imm       = r_imm;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [11:0] inst_imm;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_imm       (inst_imm),
`ifdef FETCH_MISALIGN_CHK_EN
        .misalign_err   (misalign_err),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // From REQ: request accepted, response one cycle later; ends in HOLD.
    task automatic fetch(input logic [31:0] data);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_inst_imm", {20'b0, inst_imm}, 32'h0);
        rst = 1'b0;
        #1;
        check("req_valid_after_rst", {31'b0, imem_req_valid}, 32'h1);
        check("req_addr0", imem_addr, 32'h0);

        // Basic fetch of addi x1,x0,5
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        check("wait_no_req", {31'b0, imem_req_valid}, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0050_0093;
        tick();
        imem_rsp_valid = 1'b0;
        check("t1_valid", {31'b0, inst_valid}, 32'h1);
        check("t1_inst", inst, 32'h0050_0093);
        check("t1_pc", inst_pc, 32'h0);
        check("t1_imm", {20'b0, inst_imm}, 32'h005);
        consume();
        check("t1_cons_valid", {31'b0, inst_valid}, 32'h0);
        check("t1_cons_nop", inst, 32'h0000_0013);
        check("t1_next_addr", imem_addr, 32'h4);
        check("t1_next_req", {31'b0, imem_req_valid}, 32'h1);

        // S-type split vs I-type field
        fetch(32'hFE11_2E23);
        check("t2_s_pc", inst_pc, 32'h4);
        check("t2_s_imm", {20'b0, inst_imm}, 32'hFFC);
        consume();
        check("t2_addr8", imem_addr, 32'h8);
        fetch(32'hFFC1_0093);
        check("t2_i_pc", inst_pc, 32'h8);
        check("t2_i_imm", {20'b0, inst_imm}, 32'hFFC);

        // Stall in HOLD for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_valid", {31'b0, inst_valid}, 32'h1);
            check("t3_inst", inst, 32'hFFC1_0093);
            check("t3_pc", inst_pc, 32'h8);
            check("t3_imm", {20'b0, inst_imm}, 32'hFFC);
            check("t3_no_req", {31'b0, imem_req_valid}, 32'h0);
        end
        consume();
        check("t3_addrC", imem_addr, 32'hC);

        // Redirect in WAIT, stale response dropped
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("t4_drop_no_req", {31'b0, imem_req_valid}, 32'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0000_0013;
        tick();
        imem_rsp_valid = 1'b0;
        check("t4_no_inst", {31'b0, inst_valid}, 32'h0);
        check("t4_req", {31'b0, imem_req_valid}, 32'h1);
        check("t4_addr", imem_addr, 32'h100);

        // Redirect in REQ without acceptance, then PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("t5_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0013);
        check("t5_pc", inst_pc, 32'hFFFF_FFFC);
        consume();
        check("t5_wrap", imem_addr, 32'h0);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        check("t6_err", {31'b0, misalign_err}, 32'h1);
        check("t6_addr", imem_addr, 32'h0);
`else
        check("t6_addr", imem_addr, 32'h100);
`endif

        // Redirect while holding an instruction
        fetch(32'h0010_0113);
        check("t7_valid", {31'b0, inst_valid}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("t7_cleared", {31'b0, inst_valid}, 32'h0);
        check("t7_nop", inst, 32'h0000_0013);
        check("t7_addr", imem_addr, 32'h200);

        // Reset mid-transaction; late response must be ignored
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1234_5093;
        #1;
        check("t8_addr", imem_addr, 32'h0);
        tick();
        imem_rsp_valid = 1'b0;
        check("t8_no_inst", {31'b0, inst_valid}, 32'h0);
        check("t8_req", {31'b0, imem_req_valid}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
